// File: rtl/perf_counter_sampler.sv
// Sweeps a masked set of mhpmcounter3.. over the perf_counters CSR port and queues
// {seq, idx, value} samples in a first-word-fall-through FIFO for a trace/debug sink.
module perf_counter_sampler #(
  parameter int NumCounters = 6,
  parameter int Xlen        = 64,
  parameter int FifoDepth   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cfg_en_i,
  input  logic [31:0]            cfg_period_i,
  input  logic [NumCounters-1:0] cfg_mask_i,
  input  logic                   cfg_clear_i,
  input  logic                   trigger_i,
  input  logic                   debug_mode_i,
  input  logic                   csr_busy_i,
  output logic                   perf_req_o,
  output logic [11:0]            perf_addr_o,
  output logic                   perf_we_o,
  output logic [Xlen-1:0]        perf_wdata_o,
  input  logic [Xlen-1:0]        perf_rdata_i,
  output logic                   sample_valid_o,
  input  logic                   sample_ready_i,
  output logic [4:0]             sample_idx_o,
  output logic [15:0]            sample_seq_o,
  output logic                   sample_last_o,
  output logic [63:0]            sample_data_o,
  output logic                   busy_o,
  output logic                   overrun_o,
  input  logic                   overrun_clr_i
);

  localparam logic [11:0] CsrMhpmCounter3  = 12'hB03;
  localparam logic [11:0] CsrMhpmCounter3H = 12'hB83;
  localparam int          PtrW             = $clog2(FifoDepth);

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    CLR_LO,
    CLR_HI,
    PUSH
  } state_e;

  typedef struct packed {
    logic [15:0] seq;
    logic [4:0]  idx;
    logic        last;
    logic [63:0] data;
  } sample_t;

  function automatic logic [4:0] lowest_set(input logic [NumCounters-1:0] m);
    lowest_set = '0;
    for (int k = NumCounters - 1; k >= 0; k--) begin
      if (m[k]) lowest_set = 5'(k);
    end
  endfunction

  state_e                 state_q;
  logic [4:0]             idx_q;
  logic [NumCounters-1:0] rem_q;
  logic                   clr_q;
  logic [63:0]            data_q;
  logic [15:0]            seq_q;
  logic [31:0]            timer_q;
  logic                   overrun_q;

  logic                   timer_run;
  logic                   fire;
  logic                   start_req;
  logic                   start;
  logic [63:0]            rdata64;
  logic [NumCounters-1:0] idx_onehot;
  logic [NumCounters-1:0] rem_next;
  logic                   last_sample;

  sample_t                fifo_mem [FifoDepth];
  logic [PtrW-1:0]        wr_ptr_q;
  logic [PtrW-1:0]        rd_ptr_q;
  logic [PtrW:0]          count_q;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  sample_t                head;

  assign rdata64 = 64'(perf_rdata_i);

  // ">=" rather than "==" so a period lowered below the running count fires at once
  assign timer_run = cfg_en_i & ~debug_mode_i & (cfg_period_i != 32'd0);
  assign fire      = timer_run & (timer_q >= (cfg_period_i - 32'd1));
  assign start_req = fire | (trigger_i & cfg_en_i);
  assign start     = (state_q == IDLE) & start_req & ~debug_mode_i & (cfg_mask_i != '0);

  assign idx_onehot  = NumCounters'(1) << idx_q;
  assign rem_next    = rem_q & ~idx_onehot;
  assign last_sample = (rem_next == '0);

  assign fifo_full  = (count_q == (PtrW + 1)'(FifoDepth));
  assign fifo_empty = (count_q == '0);
  assign pop        = ~fifo_empty & sample_ready_i;
  assign push       = (state_q == PUSH) & (~fifo_full | pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
    end else if (timer_run) begin
      timer_q <= fire ? 32'd0 : timer_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      clr_q   <= 1'b0;
      data_q  <= '0;
      seq_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            rem_q   <= cfg_mask_i;
            idx_q   <= lowest_set(cfg_mask_i);
            clr_q   <= cfg_clear_i;
            state_q <= RD_LO;
          end
        end
        RD_LO: begin
          if (!csr_busy_i) begin
            if (Xlen == 64) data_q <= rdata64;
            else            data_q[31:0] <= rdata64[31:0];
            state_q <= (Xlen == 32) ? RD_HI : (clr_q ? CLR_LO : PUSH);
          end
        end
        RD_HI: begin
          if (!csr_busy_i) begin
            data_q[63:32] <= rdata64[31:0];
            state_q       <= clr_q ? CLR_LO : PUSH;
          end
        end
        CLR_LO: begin
          if (!csr_busy_i) state_q <= (Xlen == 32) ? CLR_HI : PUSH;
        end
        CLR_HI: begin
          if (!csr_busy_i) state_q <= PUSH;
        end
        PUSH: begin
          if (push) begin
            rem_q <= rem_next;
            if (last_sample) begin
              seq_q   <= seq_q + 16'd1;
              state_q <= IDLE;
            end else begin
              idx_q   <= lowest_set(rem_next);
              state_q <= RD_LO;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A request arriving while a sweep runs is dropped; set has priority over clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overrun_q <= 1'b0;
    end else if (start_req && (state_q != IDLE)) begin
      overrun_q <= 1'b1;
    end else if (overrun_clr_i) begin
      overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= {seq_q, idx_q, last_sample, data_q};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + (PtrW + 1)'(1);
      else if (!push && pop) count_q <= count_q - (PtrW + 1)'(1);
    end
  end

  always_comb begin
    perf_addr_o = '0;
    case (state_q)
      RD_LO, CLR_LO: perf_addr_o = CsrMhpmCounter3 + 12'(idx_q);
      RD_HI, CLR_HI: perf_addr_o = CsrMhpmCounter3H + 12'(idx_q);
      default:       perf_addr_o = '0;
    endcase
  end

  assign perf_req_o   = (state_q == RD_LO) | (state_q == RD_HI) |
                        (state_q == CLR_LO) | (state_q == CLR_HI);
  assign perf_we_o    = ((state_q == CLR_LO) | (state_q == CLR_HI)) & ~csr_busy_i;
  assign perf_wdata_o = '0;
  assign busy_o       = (state_q != IDLE);
  assign overrun_o    = overrun_q;

  // Head fields are forced to zero when empty so the sink never sees stale RAM contents
  assign head           = fifo_mem[rd_ptr_q];
  assign sample_valid_o = ~fifo_empty;
  assign sample_idx_o   = fifo_empty ? 5'd0  : head.idx;
  assign sample_seq_o   = fifo_empty ? 16'd0 : head.seq;
  assign sample_last_o  = ~fifo_empty & head.last;
  assign sample_data_o  = fifo_empty ? 64'd0 : head.data;

endmodule

// File: tb/tb_perf_counter_sampler.sv
// Directed bench for perf_counter_sampler: a 64-bit and a 32-bit instance, each backed
// by a small perf_counters model answering reads combinationally and applying writes.
module tb_perf_counter_sampler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_en, en32, cfg_clear, trigger, trig32, debug_mode, csr_busy;
  logic        sample_ready, overrun_clr;
  logic [31:0] cfg_period;
  logic [5:0]  cfg_mask;

  logic        perf_req, perf_we, sample_valid, sample_last, busy, overrun;
  logic [11:0] perf_addr;
  logic [63:0] perf_wdata, perf_rdata, sample_data;
  logic [4:0]  sample_idx;
  logic [15:0] sample_seq;

  logic        perf_req32, perf_we32, sample_valid32, sample_last32, busy32, overrun32;
  logic [11:0] perf_addr32;
  logic [31:0] perf_wdata32, perf_rdata32;
  logic [63:0] sample_data32;
  logic [4:0]  sample_idx32;
  logic [15:0] sample_seq32;

  always #5 clk = ~clk;

  perf_counter_sampler #(.NumCounters(6), .Xlen(64), .FifoDepth(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_en_i(cfg_en), .cfg_period_i(cfg_period),
    .cfg_mask_i(cfg_mask), .cfg_clear_i(cfg_clear), .trigger_i(trigger),
    .debug_mode_i(debug_mode), .csr_busy_i(csr_busy), .perf_req_o(perf_req),
    .perf_addr_o(perf_addr), .perf_we_o(perf_we), .perf_wdata_o(perf_wdata),
    .perf_rdata_i(perf_rdata), .sample_valid_o(sample_valid), .sample_ready_i(sample_ready),
    .sample_idx_o(sample_idx), .sample_seq_o(sample_seq), .sample_last_o(sample_last),
    .sample_data_o(sample_data), .busy_o(busy), .overrun_o(overrun),
    .overrun_clr_i(overrun_clr)
  );

  perf_counter_sampler #(.NumCounters(6), .Xlen(32), .FifoDepth(4)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .cfg_en_i(en32), .cfg_period_i(32'd0),
    .cfg_mask_i(cfg_mask), .cfg_clear_i(cfg_clear), .trigger_i(trig32),
    .debug_mode_i(debug_mode), .csr_busy_i(1'b0), .perf_req_o(perf_req32),
    .perf_addr_o(perf_addr32), .perf_we_o(perf_we32), .perf_wdata_o(perf_wdata32),
    .perf_rdata_i(perf_rdata32), .sample_valid_o(sample_valid32), .sample_ready_i(sample_ready),
    .sample_idx_o(sample_idx32), .sample_seq_o(sample_seq32), .sample_last_o(sample_last32),
    .sample_data_o(sample_data32), .busy_o(busy32), .overrun_o(overrun32),
    .overrun_clr_i(overrun_clr)
  );

  // perf_counters model: counters k at 0xB03+k (low/64-bit) and 0xB83+k (high half)
  logic [63:0] cnt   [6];
  logic [63:0] cnt32 [6];
  logic        load_en, load_sel32;
  int          load_idx;
  logic [63:0] load_val;
  logic [2:0]  ri, r32lo, r32hi;
  logic        in64, in32lo, in32hi;

  always_comb begin
    ri         = 3'(perf_addr - 12'hB03);
    r32lo      = 3'(perf_addr32 - 12'hB03);
    r32hi      = 3'(perf_addr32 - 12'hB83);
    in64       = (perf_addr >= 12'hB03) && (perf_addr <= 12'hB08);
    in32lo     = (perf_addr32 >= 12'hB03) && (perf_addr32 <= 12'hB08);
    in32hi     = (perf_addr32 >= 12'hB83) && (perf_addr32 <= 12'hB88);
    perf_rdata = '0;
    if (in64) perf_rdata = cnt[ri];
    perf_rdata32 = '0;
    if (in32lo)      perf_rdata32 = cnt32[r32lo][31:0];
    else if (in32hi) perf_rdata32 = cnt32[r32hi][63:32];
  end

  always @(posedge clk) begin
    if (load_en) begin
      if (load_sel32) cnt32[load_idx] <= load_val;
      else            cnt[load_idx]   <= load_val;
    end
    if (perf_we && in64) cnt[ri] <= perf_wdata;
    if (perf_we32 && in32lo) cnt32[r32lo][31:0]  <= perf_wdata32;
    if (perf_we32 && in32hi) cnt32[r32hi][63:32] <= perf_wdata32;
  end

  typedef struct {
    logic [4:0]  idx;
    logic [15:0] seq;
    logic        last;
    logic [63:0] data;
  } smp_t;

  smp_t        got[$];
  logic [11:0] rd_log[$];
  logic [11:0] we_log[$];
  int          start_cyc[$];
  int          we_bad, busy_cyc, cyc, busy_first, valid_first;
  logic        busy_prev, mon_clr;

  // Observes the 64-bit instance on the falling edge, away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (mon_clr) begin
      got.delete(); rd_log.delete(); we_log.delete(); start_cyc.delete();
      we_bad = 0; busy_cyc = 0; busy_first = -1; valid_first = -1;
    end else begin
      if (sample_valid && sample_ready)
        got.push_back('{sample_idx, sample_seq, sample_last, sample_data});
      if (perf_req && !perf_we && !csr_busy) rd_log.push_back(perf_addr);
      if (perf_we) begin
        we_log.push_back(perf_addr);
        if (csr_busy || perf_wdata != 64'd0) we_bad++;
      end
      if (busy) begin
        busy_cyc++;
        if (busy_first < 0) busy_first = cyc;
      end
      if (sample_valid && valid_first < 0) valid_first = cyc;
      if (busy && !busy_prev) start_cyc.push_back(cyc);
    end
    busy_prev = busy;
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearMon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
  endtask

  task automatic loadCnt(input logic sel32, input int k, input logic [63:0] v);
    load_sel32 = sel32; load_idx = k; load_val = v; load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  typedef struct {
    logic [5:0] mask;
    logic       clr;
    logic       tog;
    int         exp_busy;
  } vec_t;

  vec_t        vecs[8];
  logic [63:0] exp_cnt[6];
  logic [15:0] tb_seq;

  // Trigger in cycle 0; with tog set, csr_busy is high on every odd cycle after it
  task automatic applyStimulus(input vec_t v);
    clearMon();
    cfg_mask  = v.mask;
    cfg_clear = v.clr;
    trigger   = 1'b1;
    csr_busy  = 1'b0;
    tick();
    trigger = 1'b0;
    for (int c = 1; c < 60; c++) begin
      csr_busy = v.tog & c[0];
      tick();
    end
    csr_busy = 1'b0;
  endtask

  task automatic checkVector(input vec_t v);
    int n, hi, j;
    n  = $countones(v.mask);
    hi = -1;
    for (int k = 0; k < 6; k++) if (v.mask[k]) hi = k;
    checkOutput("busy_cycles", 64'(busy_cyc), 64'(v.exp_busy));
    checkOutput("sample_count", 64'(got.size()), 64'(n));
    checkOutput("read_count", 64'(rd_log.size()), 64'(n));
    checkOutput("write_count", 64'(we_log.size()), v.clr ? 64'(n) : 64'd0);
    checkOutput("write_illegal", 64'(we_bad), 64'd0);
    if (!v.tog && !v.clr && n > 0)
      checkOutput("first_latency", 64'(valid_first - busy_first), 64'd2);
    j = 0;
    for (int k = 0; k < 6; k++) begin
      if (v.mask[k]) begin
        if (j < got.size()) begin
          checkOutput("sample_idx", 64'(got[j].idx), 64'(k));
          checkOutput("sample_seq", 64'(got[j].seq), 64'(tb_seq));
          checkOutput("sample_last", 64'(got[j].last), 64'(k == hi));
          checkOutput("sample_data", got[j].data, exp_cnt[k]);
        end
        if (j < rd_log.size()) checkOutput("read_addr", 64'(rd_log[j]), 64'(12'hB03 + k));
        if (v.clr) begin
          if (j < we_log.size()) checkOutput("write_addr", 64'(we_log[j]), 64'(12'hB03 + k));
          exp_cnt[k] = 64'd0;
        end
        j++;
      end
    end
    if (n > 0) tb_seq++;
  endtask

  logic [11:0] rd32[$];
  logic [11:0] we32[$];
  int          wbad32;
  logic        seen32;
  logic [63:0] data32;
  logic        last32;

  initial begin
    rst_n = 1'b0; cfg_en = 1'b0; en32 = 1'b0; cfg_clear = 1'b0; trigger = 1'b0;
    trig32 = 1'b0; debug_mode = 1'b0; csr_busy = 1'b0; sample_ready = 1'b0;
    overrun_clr = 1'b0; cfg_period = 32'd0; cfg_mask = 6'd0; mon_clr = 1'b1;
    load_en = 1'b0; load_sel32 = 1'b0; load_idx = 0; load_val = 64'd0;
    cyc = 0; busy_prev = 1'b0; tb_seq = 16'd0;
    tick(); tick();

    checkOutput("reset_perf_req", 64'(perf_req), 64'd0);
    checkOutput("reset_perf_addr", 64'(perf_addr), 64'd0);
    checkOutput("reset_perf_we", 64'(perf_we), 64'd0);
    checkOutput("reset_valid", 64'(sample_valid), 64'd0);
    checkOutput("reset_data", sample_data, 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_overrun", 64'(overrun), 64'd0);
    rst_n = 1'b1;
    tick();

    exp_cnt[0] = 64'h0000_0000_0000_1234;
    exp_cnt[1] = 64'h0123_4567_89AB_CDEF;
    exp_cnt[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_cnt[3] = 64'h8000_0000_0000_0001;
    exp_cnt[4] = 64'h0000_0001_0000_0000;
    exp_cnt[5] = 64'hDEAD_BEEF_CAFE_F00D;
    for (int k = 0; k < 6; k++) loadCnt(1'b0, k, exp_cnt[k]);
    loadCnt(1'b1, 0, 64'h1_0000_0002);
    loadCnt(1'b1, 1, 64'h7777_8888_9999_AAAA);

    cfg_en       = 1'b1;
    sample_ready = 1'b1;

    vecs[0] = '{6'b000101, 1'b0, 1'b0, 4};
    vecs[1] = '{6'b111111, 1'b0, 1'b0, 12};
    vecs[2] = '{6'b000001, 1'b1, 1'b0, 3};
    vecs[3] = '{6'b000001, 1'b0, 1'b0, 2};
    vecs[4] = '{6'b101010, 1'b0, 1'b1, 7};
    vecs[5] = '{6'b100000, 1'b1, 1'b1, 5};
    vecs[6] = '{6'b000000, 1'b0, 1'b0, 0};
    vecs[7] = '{6'b100001, 1'b0, 1'b0, 4};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      checkVector(vecs[i]);
    end
    checkOutput("model_cnt0_cleared", cnt[0], 64'd0);
    checkOutput("model_cnt5_cleared", cnt[5], 64'd0);
    checkOutput("model_cnt1_kept", cnt[1], 64'h0123_4567_89AB_CDEF);

    // Backpressure: four samples fill the FIFO, the fifth waits in PUSH
    clearMon();
    sample_ready = 1'b0; cfg_mask = 6'b111111; cfg_clear = 1'b0;
    trigger = 1'b1; tick(); trigger = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    checkOutput("stall_busy", 64'(busy), 64'd1);
    checkOutput("stall_valid", 64'(sample_valid), 64'd1);
    checkOutput("stall_head_idx", 64'(sample_idx), 64'd0);
    checkOutput("stall_head_data", sample_data, exp_cnt[0]);
    checkOutput("stall_reads", 64'(rd_log.size()), 64'd5);
    checkOutput("stall_popped", 64'(got.size()), 64'd0);
    checkOutput("overrun_before", 64'(overrun), 64'd0);
    trigger = 1'b1; tick(); trigger = 1'b0;
    checkOutput("overrun_set", 64'(overrun), 64'd1);
    trigger = 1'b1; overrun_clr = 1'b1; tick(); trigger = 1'b0;
    checkOutput("overrun_set_wins", 64'(overrun), 64'd1);
    tick();
    overrun_clr = 1'b0;
    checkOutput("overrun_cleared", 64'(overrun), 64'd0);
    sample_ready = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    checkOutput("release_count", 64'(got.size()), 64'd6);
    for (int j = 0; j < got.size() && j < 6; j++) begin
      checkOutput("release_idx", 64'(got[j].idx), 64'(j));
      checkOutput("release_last", 64'(got[j].last), 64'(j == 5));
      checkOutput("release_seq", 64'(got[j].seq), 64'(tb_seq));
      checkOutput("release_data", got[j].data, exp_cnt[j]);
    end
    checkOutput("release_idle", 64'(busy), 64'd0);
    tb_seq++;

    // Periodic timer, then a 30-cycle debug window between the 2nd and 3rd sweep
    clearMon();
    cfg_mask = 6'b000010; cfg_period = 32'd100;
    for (int i = 0; i < 360; i++) begin
      debug_mode = (i >= 240) && (i < 270);
      tick();
    end
    debug_mode = 1'b0; cfg_period = 32'd0;
    tick();
    checkOutput("timer_starts", 64'(start_cyc.size()), 64'd3);
    if (start_cyc.size() >= 3) begin
      checkOutput("timer_period", 64'(start_cyc[1] - start_cyc[0]), 64'd100);
      checkOutput("timer_debug_delay", 64'(start_cyc[2] - start_cyc[1]), 64'd130);
    end
    checkOutput("timer_samples", 64'(got.size()), 64'd3);
    for (int j = 0; j < got.size() && j < 3; j++)
      checkOutput("timer_seq", 64'(got[j].seq), 64'(tb_seq + 16'(j)));
    tb_seq = tb_seq + 16'd3;

    // 32-bit instance: low then high half read, then both halves cleared
    rd32.delete(); we32.delete(); wbad32 = 0; seen32 = 1'b0; data32 = '0; last32 = 1'b0;
    en32 = 1'b1; cfg_mask = 6'b000001; cfg_clear = 1'b1;
    trig32 = 1'b1; tick(); trig32 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (perf_req32 && !perf_we32) rd32.push_back(perf_addr32);
      if (perf_we32) begin
        we32.push_back(perf_addr32);
        if (perf_wdata32 != 32'd0) wbad32++;
      end
      if (sample_valid32 && !seen32) begin
        seen32 = 1'b1; data32 = sample_data32; last32 = sample_last32;
      end
      tick();
    end
    en32 = 1'b0; cfg_clear = 1'b0;
    checkOutput("x32_sample_seen", 64'(seen32), 64'd1);
    checkOutput("x32_data", data32, 64'h1_0000_0002);
    checkOutput("x32_last", 64'(last32), 64'd1);
    checkOutput("x32_reads", 64'(rd32.size()), 64'd2);
    if (rd32.size() >= 2) begin
      checkOutput("x32_read_lo", 64'(rd32[0]), 64'hB03);
      checkOutput("x32_read_hi", 64'(rd32[1]), 64'hB83);
    end
    checkOutput("x32_writes", 64'(we32.size()), 64'd2);
    if (we32.size() >= 2) begin
      checkOutput("x32_write_lo", 64'(we32[0]), 64'hB03);
      checkOutput("x32_write_hi", 64'(we32[1]), 64'hB83);
    end
    checkOutput("x32_wdata", 64'(wbad32), 64'd0);
    checkOutput("x32_model_cleared", cnt32[0], 64'd0);
    checkOutput("x32_model_kept", cnt32[1], 64'h7777_8888_9999_AAAA);

    // Reset in the middle of a read-and-clear sweep must not issue the write
    clearMon();
    cfg_mask = 6'b000010; cfg_clear = 1'b1;
    trigger = 1'b1; tick(); trigger = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("rst_mid_writes", 64'(we_log.size()), 64'd0);
    checkOutput("rst_mid_busy", 64'(busy), 64'd0);
    checkOutput("rst_mid_valid", 64'(sample_valid), 64'd0);
    checkOutput("rst_mid_cnt1", cnt[1], exp_cnt[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
